// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two clients.
// Accept -> execute (one cycle) -> hold response until the client takes it.
module alu_arbiter #(
  parameter int WIDTH  = 5,
  parameter int OP_W   = 3,
  parameter int FLAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*WIDTH-1:0]  req_a,
  input  logic [2*WIDTH-1:0]  req_b,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [WIDTH-1:0]    rsp_result,
  output logic [FLAG_W-1:0]   rsp_flags,
  output logic                rsp_err,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OP_W-1:0]     alu_ctrl,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [FLAG_W-1:0]   alu_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic [FLAG_W-1:0]   flg_q, flg_d;
  logic                err_q, err_d;

  logic                any_req;
  logic                pick;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic [OP_W-1:0]     sel_op;
  logic                sel_legal;

  // Ops the shared ALU implements; anything else is answered with an error.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_W'(0)) || (op == OP_W'(2)) ||
           (op == OP_W'(3)) || (op == OP_W'(4)) ||
           (op == OP_W'(7));
  endfunction

  // Grant pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    pick = last_q;
    unique case (req_valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_q;
      default: pick = last_q;
    endcase
  end

  assign any_req = |req_valid;

  // Operand mux for the picked requester.
  always_comb begin
    sel_a  = req_a[WIDTH-1:0];
    sel_b  = req_b[WIDTH-1:0];
    sel_op = req_op[OP_W-1:0];
    if (pick) begin
      sel_a  = req_a[2*WIDTH-1:WIDTH];
      sel_b  = req_b[2*WIDTH-1:WIDTH];
      sel_op = req_op[2*OP_W-1:OP_W];
    end
  end

  assign sel_legal = op_legal(sel_op);

  // Next-state and datapath latches for the accept/exec/resp sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flg_d   = flg_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d  = pick;
          last_d = pick;
          a_d    = sel_a;
          b_d    = sel_b;
          op_d   = sel_op;
          if (sel_legal) begin
            state_d = EXEC;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            res_d   = '0;
            flg_d   = '0;
          end
        end
      end
      EXEC: begin
        res_d   = alu_result;
        flg_d   = alu_flags;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any in-flight or pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (state_q == IDLE && !reset) begin
      req_ready = (pick ? 2'b10 : 2'b01) & req_valid;
    end
    if (state_q == RESP) begin
      rsp_valid = gnt_q ? 2'b10 : 2'b01;
    end
  end

  // The ALU only sees operands during the execute cycle.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    if (state_q == EXEC) begin
      alu_a    = a_q;
      alu_b    = b_q;
      alu_ctrl = op_q;
    end
  end

  assign rsp_result = res_q;
  assign rsp_flags  = flg_q;
  assign rsp_err    = err_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one 5-bit combinational ALU instance between independent clients.
- Accepts an operation through a valid/ready handshake and drives the ALU operands and control from registered copies.
- Captures the ALU's Result and ALUFlags into a response register, then returns them through a valid/ready response handshake.
- Sits between client blocks (datapath sequencers, test drivers) and the shared ALU.

Parameters:
- WIDTH, 5, operand/result width; must match the ALU.
- OP_W, 3, ALU control width.
- FLAG_W, 4, flag width, ordered {neg, zero, carry, overflow}.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  2  per-requester request valid; bit k = requester k.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_a  in  2*WIDTH  operand a; requester k at [k*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand b; same packing as req_a.
- req_op  in  2*OP_W  ALU control; requester k at [k*OP_W +: OP_W].
- rsp_valid  out  2  per-requester response valid; one-hot or zero.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  WIDTH  captured result, shared by both requesters; meaningful only with rsp_valid.
- rsp_flags  out  FLAG_W  captured flags.
- rsp_err  out  1  set when the op was illegal.
- alu_a  out  WIDTH  to ALU input a.
- alu_b  out  WIDTH  to ALU input b.
- alu_ctrl  out  OP_W  to ALU ALUControl.
- alu_result  in  WIDTH  from ALU Result.
- alu_flags  in  FLAG_W  from ALU ALUFlags.

Behaviour:
- Reset values: state=IDLE, last_grant=1, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_a/alu_b/alu_ctrl=0, operand/op latches=0.
- States: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - req_ready[g] is combinational: state==IDLE && req_valid[g].
- IDLE, acceptance:
  - On acceptance, latch a, b, op and g; set last_grant=g.
  - Legal op (000, 010, 011, 100, 111): go to EXEC.
  - Illegal op: go straight to RESP with rsp_err=1, result=0, flags=0.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_ctrl are driven from the latches.
  - At the clock edge, capture alu_result→rsp_result and alu_flags→rsp_flags, set rsp_err=0, go to RESP.
  - Outside EXEC, alu_* hold 0.
- RESP:
  - rsp_valid[g]=1; rsp_result/flags/err stay stable until rsp_ready[g]=1.
  - On that handshake edge, return to IDLE; rsp_valid drops in the next cycle.
  - No new request is accepted during EXEC or RESP (req_ready=0).
- Latency:
  - Accept at edge N, capture at edge N+1, rsp_valid visible in cycle after N+1.
  - Minimum issue interval is 3 cycles (accept, exec, resp with immediate rsp_ready).
- rsp_ready:
  - rsp_ready on a non-granted bit is ignored.
  - rsp_ready asserted before rsp_valid has no effect.
- Requester contract: req_a/b/op stay stable while req_valid is high and not yet accepted. The block itself samples only at acceptance.
- Requester dropping valid before acceptance: no grant, no effect on last_grant.
- Reset mid-operation (EXEC or RESP):
  - Immediate return to IDLE with reset values.
  - Any pending response is discarded and never presented.
  - last_grant=1, so requester 0 wins the next tie.
- The block does not compute flags; it passes the ALU's flags through unmodified.

Test Plan:
- Req0 only, op=000, a=12, b=7 → req_ready[0] in accept cycle; alu_ctrl=000 during EXEC; rsp_valid=2'b01, rsp_result=5'b10011, rsp_flags=4'b1001, rsp_err=0 two cycles after accept.
- Both valid from reset; req0 op=010 a=5'b10110 b=5'b01110, req1 op=011 a=5'b00001 b=5'b00100 → req0 served first: result=5'b00110, flags=4'b0000. Then req1: result=5'b00101, flags=4'b0000. Grant order 0,1,0,1 while both stay valid.
- Req1 op=001 (illegal) → no EXEC cycle (alu_ctrl stays 0); rsp_valid=2'b10 one cycle after accept, rsp_err=1, result=0, flags=0.
- Backpressure: req0 op=100 a=5'b10101 b=5'b11111; hold rsp_ready=0 for 5 cycles while req1 is valid → rsp_valid[0] and rsp_result=5'b01010 stay stable; req_ready stays 0. After rsp_ready[0], req1 is accepted in the following IDLE cycle.
- Reset asserted asynchronously during EXEC of req0 → all outputs reach reset values without a clock edge; after release, no rsp_valid appears until a new request.
- Req0 op=111 a=5'b11101 → result=5'b10011, flags=4'b1000. Stray rsp_ready[1]=1 throughout has no effect.
